can_tx_scheduler: RTL and testbench

CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

---
 rtl/can_tx_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: arbitrates four requesters by ID, waits for an idle bus,
// launches frames to the CAN node and handles retries, arbitration loss and 4-phase ack/fail.
module can_tx_scheduler #(
   parameter int MAX_RETRY = 7,
   parameter int IDLE_BITS = 11
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [3:0]  req,
   input  logic [43:0] req_id,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ack,
   output logic [3:0]  req_fail,
   input  logic        bit_tick,
   input  logic        can_rx,
   output logic        tx_start,
   output logic [10:0] tx_id,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   input  logic        tx_lost,
   input  logic        tx_err,
   output logic        bus_idle,
   output logic [2:0]  state,
   output logic [2:0]  retry_cnt
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SELECT   = 3'd1,
      WAIT_BUS = 3'd2,
      LAUNCH   = 3'd3,
      BUSY     = 3'd4,
      DONE     = 3'd5,
      FAIL     = 3'd6
   } state_t;

   localparam int              CNT_W     = $clog2(IDLE_BITS + 1);
   localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_BITS);
   localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] idle_cnt, idle_cnt_d;
   logic [1:0]       idx;
   logic [3:0]       idx_onehot;
   logic [2:0]       retry_d, retry_inc;
   logic [3:0]       ack_d, fail_d;
   logic             any_req;
   logic [1:0]       win_idx;
   logic [10:0]      win_id;

   assign state      = state_q;
   assign idx_onehot = 4'b0001 << idx;
   assign retry_inc  = retry_cnt + 3'd1;

   // Recessive-bit run length; any dominant bit restarts the idle qualification.
   always_comb begin
      idle_cnt_d = idle_cnt;
      if (bit_tick) begin
         if (!can_rx)
            idle_cnt_d = '0;
         else if (idle_cnt != IDLE_MAX)
            idle_cnt_d = idle_cnt + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         idle_cnt <= '0;
         bus_idle <= 1'b0;
      end else begin
         idle_cnt <= idle_cnt_d;
         bus_idle <= (idle_cnt_d == IDLE_MAX);
      end
   end

   // Lowest ID wins; strict compare keeps the lower index on equal IDs.
   always_comb begin
      any_req = 1'b0;
      win_idx = '0;
      win_id  = '0;
      for (int k = 0; k < 4; k++) begin
         if (req[k] && (!any_req || req_id[11*k +: 11] < win_id)) begin
            any_req = 1'b1;
            win_idx = 2'(k);
            win_id  = req_id[11*k +: 11];
         end
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      retry_d = retry_cnt;
      ack_d   = req_ack;
      fail_d  = req_fail;
      unique case (state_q)
         IDLE: begin
            if (|req) state_d = SELECT;
         end
         SELECT: begin
            if (any_req) begin
               state_d = WAIT_BUS;
            end else begin
               state_d = IDLE;
               retry_d = '0;
            end
         end
         WAIT_BUS: begin
            if (!req[idx]) begin
               state_d = IDLE;
               retry_d = '0;
            end else if (bus_idle) begin
               state_d = LAUNCH;
            end
         end
         LAUNCH: state_d = BUSY;
         BUSY: begin
            if (tx_done) begin
               state_d = DONE;
            end else if (tx_lost) begin
               state_d = SELECT;
            end else if (tx_err) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_MAX) ? FAIL : WAIT_BUS;
            end
         end
         DONE: begin
            if (req_ack == 4'b0000) begin
               ack_d = idx_onehot;
            end else if (!req[idx]) begin
               ack_d   = '0;
               state_d = IDLE;
               retry_d = '0;
            end
         end
         FAIL: begin
            if (req_fail == 4'b0000) begin
               fail_d = idx_onehot;
            end else if (!req[idx]) begin
               fail_d  = '0;
               state_d = IDLE;
               retry_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            retry_d = '0;
            ack_d   = '0;
            fail_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         tx_start  <= 1'b0;
         idx       <= '0;
         tx_id     <= '0;
         tx_data   <= '0;
         retry_cnt <= '0;
         req_ack   <= '0;
         req_fail  <= '0;
      end else begin
         state_q   <= state_d;
         tx_start  <= (state_d == LAUNCH);
         retry_cnt <= retry_d;
         req_ack   <= ack_d;
         req_fail  <= fail_d;
         // Frame fields are frozen here until the next arbitration round.
         if (state_q == SELECT && any_req) begin
            idx     <= win_idx;
            tx_id   <= win_id;
            tx_data <= req_data[{win_idx, 3'b000} +: 8];
         end
      end
   end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: directed scenarios plus randomized
// arbitration and idle-counter runs scored against a transaction-level model.
module tb_can_tx_scheduler;

   localparam int IDLE_BITS = 11;
   localparam int MAX_RETRY = 7;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [3:0]  req = '0;
   logic [43:0] req_id = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ack, req_fail;
   logic        bit_tick = 1'b0;
   logic        can_rx = 1'b1;
   logic        tx_start;
   logic [10:0] tx_id;
   logic [7:0]  tx_data;
   logic        tx_done = 1'b0, tx_lost = 1'b0, tx_err = 1'b0;
   logic        bus_idle;
   logic [2:0]  state, retry_cnt;

   int errors = 0;
   int checks = 0;
   int launch_count = 0;
   int onehot_viol = 0;

   logic [10:0] tb_id  [4];
   logic [7:0]  tb_dat [4];

   can_tx_scheduler #(.MAX_RETRY(MAX_RETRY), .IDLE_BITS(IDLE_BITS)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .req(req), .req_id(req_id), .req_data(req_data),
      .req_ack(req_ack), .req_fail(req_fail), .bit_tick(bit_tick), .can_rx(can_rx),
      .tx_start(tx_start), .tx_id(tx_id), .tx_data(tx_data), .tx_done(tx_done),
      .tx_lost(tx_lost), .tx_err(tx_err), .bus_idle(bus_idle), .state(state),
      .retry_cnt(retry_cnt)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (tx_start === 1'b1) launch_count++;
      if ($countones(req_ack | req_fail) > 1) onehot_viol++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic tick(input bit rx);
      bit_tick = 1'b1;
      can_rx   = rx;
      cyc();
      bit_tick = 1'b0;
      can_rx   = 1'b1;
      cyc();
   endtask

   task automatic ticks(input int n, input bit rx);
      repeat (n) tick(rx);
   endtask

   task automatic apply_cfg();
      for (int k = 0; k < 4; k++) begin
         req_id[11*k +: 11] = tb_id[k];
         req_data[8*k +: 8] = tb_dat[k];
      end
   endtask

   task automatic do_reset();
      RESET_N  = 1'b0;
      req      = '0;
      bit_tick = 1'b0;
      can_rx   = 1'b1;
      tx_done  = 1'b0;
      tx_lost  = 1'b0;
      tx_err   = 1'b0;
      cyc(2);
      RESET_N = 1'b1;
      cyc();
   endtask

   // Model arbitration: smallest {id, index} key among pending requesters.
   function automatic int model_pick(input logic [3:0] m);
      int best = -1;
      int best_key = 0;
      for (int k = 0; k < 4; k++) begin
         if (m[k] && (best < 0 || int'(tb_id[k]) * 4 + k < best_key)) begin
            best     = k;
            best_key = int'(tb_id[k]) * 4 + k;
         end
      end
      return best;
   endfunction

   task automatic wait_launch(input logic [10:0] eid, input logic [7:0] ed,
                              input logic [2:0] eretry, input string name);
      int n;
      n = 0;
      while (tx_start !== 1'b1 && n < 60) begin
         cyc();
         n++;
      end
      checks++;
      if (tx_start !== 1'b1) begin
         errors++;
         $display("FAIL %s launch: no tx_start within 60 cycles", name);
      end else begin
         checks++;
         if (tx_id !== eid || tx_data !== ed) begin
            errors++;
            $display("FAIL %s frame: got id=%h data=%h, want id=%h data=%h", name, tx_id, tx_data, eid, ed);
         end
         checks++;
         if (retry_cnt !== eretry) begin
            errors++;
            $display("FAIL %s retry at launch: got %0d want %0d", name, retry_cnt, eretry);
         end
      end
   endtask

   task automatic node_pulse(input bit d, input bit l, input bit e, input string name);
      cyc();
      checks++;
      if (state !== 3'd4) begin
         errors++;
         $display("FAIL %s busy: state=%0d want 4", name, state);
      end
      tx_done = d;
      tx_lost = l;
      tx_err  = e;
      cyc();
      tx_done = 1'b0;
      tx_lost = 1'b0;
      tx_err  = 1'b0;
   endtask

   task automatic wait_resp(input logic [3:0] eack, input logic [3:0] efail, input string name);
      int n;
      n = 0;
      while ((req_ack | req_fail) === 4'b0000 && n < 20) begin
         cyc();
         n++;
      end
      checks++;
      if (req_ack !== eack || req_fail !== efail) begin
         errors++;
         $display("FAIL %s response: ack=%b fail=%b, want ack=%b fail=%b", name, req_ack, req_fail, eack, efail);
      end
   endtask

   task automatic release_req(input int k, input string name);
      req[k] = 1'b0;
      cyc();
      checks++;
      if (req_ack !== 4'b0000 || req_fail !== 4'b0000 || state !== 3'd0 || retry_cnt !== 3'd0) begin
         errors++;
         $display("FAIL %s release: ack=%b fail=%b state=%0d retry=%0d, want 0/0/0/0",
                  name, req_ack, req_fail, state, retry_cnt);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (state !== 3'd0 || tx_start !== 1'b0 || req_ack !== 4'b0 || req_fail !== 4'b0 ||
          tx_id !== 11'h0 || tx_data !== 8'h0 || retry_cnt !== 3'd0 || bus_idle !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: state=%0d start=%b ack=%b fail=%b id=%h data=%h retry=%0d idle=%b, want all 0",
                  state, tx_start, req_ack, req_fail, tx_id, tx_data, retry_cnt, bus_idle);
      end
      ticks(IDLE_BITS - 1, 1'b1);
      checks++;
      if (bus_idle !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_early: bus_idle=%b want 0", bus_idle);
      end
      tick(1'b1);
      checks++;
      if (bus_idle !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle_reached: bus_idle=%b want 1", bus_idle);
      end
   endtask

   task automatic test_idle_counter();
      int m;
      bit rx;
      do_reset();
      m = 0;
      repeat (120) begin
         if ($urandom_range(0, 3) == 0) begin
            bit_tick = 1'b0;
            can_rx   = 1'($urandom);
            cyc();
         end else begin
            rx       = ($urandom_range(0, 5) != 0);
            bit_tick = 1'b1;
            can_rx   = rx;
            cyc();
            bit_tick = 1'b0;
            m = rx ? ((m < IDLE_BITS) ? m + 1 : IDLE_BITS) : 0;
         end
         checks++;
         if (bus_idle !== (m == IDLE_BITS)) begin
            errors++;
            $display("FAIL idle_counter: bus_idle=%b want %b (run=%0d)", bus_idle, (m == IDLE_BITS), m);
         end
      end
      can_rx = 1'b1;
   endtask

   task automatic test_single();
      int base;
      do_reset();
      base = launch_count;
      tb_id[2] = 11'h123; tb_dat[2] = 8'hA5;
      apply_cfg();
      req = 4'b0100;
      ticks(IDLE_BITS - 1, 1'b1);
      cyc(3);
      checks++;
      if (launch_count != base || state !== 3'd2) begin
         errors++;
         $display("FAIL single_gate: launches=%0d state=%0d, want 0 launches in state 2", launch_count - base, state);
      end
      tick(1'b1);
      wait_launch(11'h123, 8'hA5, 3'd0, "single");
      node_pulse(1'b1, 1'b0, 1'b0, "single");
      wait_resp(4'b0100, 4'b0000, "single");
      cyc(5);
      checks++;
      if (req_ack !== 4'b0100) begin
         errors++;
         $display("FAIL single_hold: ack=%b want 0100", req_ack);
      end
      release_req(2, "single");
      checks++;
      if (launch_count - base != 1) begin
         errors++;
         $display("FAIL single_count: launches=%0d want 1", launch_count - base);
      end
   endtask

   task automatic test_priority();
      int order [3];
      order = '{1, 3, 0};
      tb_id[0] = 11'h200; tb_id[1] = 11'h050; tb_id[2] = 11'h010; tb_id[3] = 11'h050;
      tb_dat[0] = 8'h10;  tb_dat[1] = 8'h11;  tb_dat[2] = 8'h12;  tb_dat[3] = 8'h13;
      apply_cfg();
      req = 4'b1011;
      foreach (order[i]) begin
         wait_launch(tb_id[order[i]], tb_dat[order[i]], 3'd0, "priority");
         node_pulse(1'b1, 1'b0, 1'b0, "priority");
         wait_resp(4'b0001 << order[i], 4'b0000, "priority");
         release_req(order[i], "priority");
      end
   endtask

   task automatic test_random_arbitration();
      logic [3:0] mask;
      int w, errs, r;
      bit lost;
      for (int round = 0; round < 8; round++) begin
         for (int k = 0; k < 4; k++) begin
            tb_id[k]  = ($urandom_range(0, 2) == 0) ? 11'h040 : 11'($urandom);
            tb_dat[k] = 8'($urandom);
         end
         apply_cfg();
         mask = 4'($urandom_range(1, 15));
         req  = mask;
         while (mask != 4'b0000) begin
            w    = model_pick(mask);
            errs = $urandom_range(0, 2);
            lost = 1'($urandom_range(0, 1));
            r    = 0;
            wait_launch(tb_id[w], tb_dat[w], 3'(r), "random");
            for (int e = 0; e < errs; e++) begin
               node_pulse(1'b0, 1'b0, 1'b1, "random_err");
               r++;
               checks++;
               if (retry_cnt !== 3'(r)) begin
                  errors++;
                  $display("FAIL random_retry: got %0d want %0d", retry_cnt, r);
               end
               wait_launch(tb_id[w], tb_dat[w], 3'(r), "random_relaunch");
            end
            if (lost) begin
               node_pulse(1'b0, 1'b1, 1'b0, "random_lost");
               wait_launch(tb_id[w], tb_dat[w], 3'(r), "random_rearb");
            end
            node_pulse(1'b1, 1'b0, 1'b0, "random_done");
            wait_resp(4'b0001 << w, 4'b0000, "random");
            release_req(w, "random");
            mask[w] = 1'b0;
         end
      end
   endtask

   task automatic test_retry_limit();
      int base;
      base = launch_count;
      tb_id[0] = 11'h0AB; tb_dat[0] = 8'h5C;
      apply_cfg();
      req = 4'b0001;
      for (int i = 1; i <= MAX_RETRY; i++) begin
         wait_launch(11'h0AB, 8'h5C, 3'(i - 1), "retry");
         node_pulse(1'b0, 1'b0, 1'b1, "retry");
         checks++;
         if (retry_cnt !== 3'(i) || state !== ((i == MAX_RETRY) ? 3'd6 : 3'd2)) begin
            errors++;
            $display("FAIL retry_step%0d: retry=%0d state=%0d, want retry=%0d state=%0d",
                     i, retry_cnt, state, i, (i == MAX_RETRY) ? 6 : 2);
         end
      end
      wait_resp(4'b0000, 4'b0001, "retry");
      cyc(6);
      checks++;
      if (launch_count - base != MAX_RETRY || req_fail !== 4'b0001) begin
         errors++;
         $display("FAIL retry_total: launches=%0d fail=%b, want %0d launches fail=0001",
                  launch_count - base, req_fail, MAX_RETRY);
      end
      release_req(0, "retry");
   endtask

   task automatic test_arb_loss();
      tb_id[0] = 11'h300; tb_dat[0] = 8'h30;
      tb_id[2] = 11'h100; tb_dat[2] = 8'h21;
      apply_cfg();
      req = 4'b0001;
      wait_launch(11'h300, 8'h30, 3'd0, "loss_first");
      node_pulse(1'b0, 1'b0, 1'b1, "loss_err");
      wait_launch(11'h300, 8'h30, 3'd1, "loss_second");
      req[2] = 1'b1;
      cyc(3);
      checks++;
      if (state !== 3'd4 || tx_id !== 11'h300 || tx_data !== 8'h30) begin
         errors++;
         $display("FAIL loss_no_preempt: state=%0d id=%h data=%h, want 4/300/30", state, tx_id, tx_data);
      end
      node_pulse(1'b0, 1'b1, 1'b0, "loss_lost");
      checks++;
      if (state !== 3'd1 || retry_cnt !== 3'd1) begin
         errors++;
         $display("FAIL loss_select: state=%0d retry=%0d, want 1/1", state, retry_cnt);
      end
      wait_launch(11'h100, 8'h21, 3'd1, "loss_winner2");
      node_pulse(1'b1, 1'b0, 1'b0, "loss_done2");
      wait_resp(4'b0100, 4'b0000, "loss_req2");
      release_req(2, "loss_req2");
      wait_launch(11'h300, 8'h30, 3'd0, "loss_req0");
      node_pulse(1'b1, 1'b0, 1'b0, "loss_done0");
      wait_resp(4'b0001, 4'b0000, "loss_req0");
      release_req(0, "loss_req0");
   endtask

   task automatic test_bus_gating();
      int base;
      do_reset();
      base = launch_count;
      tb_id[1] = 11'h0F0; tb_dat[1] = 8'h77;
      apply_cfg();
      req = 4'b0010;
      ticks(9, 1'b1);
      tick(1'b0);
      ticks(IDLE_BITS - 1, 1'b1);
      cyc(3);
      checks++;
      if (launch_count != base || bus_idle !== 1'b0) begin
         errors++;
         $display("FAIL gating_hold: launches=%0d bus_idle=%b, want 0/0", launch_count - base, bus_idle);
      end
      tick(1'b1);
      wait_launch(11'h0F0, 8'h77, 3'd0, "gating");
      node_pulse(1'b1, 1'b0, 1'b0, "gating");
      wait_resp(4'b0010, 4'b0000, "gating");
      release_req(1, "gating");
   endtask

   task automatic test_reset_mid_busy();
      tb_id[3] = 11'h055; tb_dat[3] = 8'h99;
      apply_cfg();
      req = 4'b1000;
      wait_launch(11'h055, 8'h99, 3'd0, "rst_busy");
      cyc();
      checks++;
      if (state !== 3'd4) begin
         errors++;
         $display("FAIL rst_busy_pre: state=%0d want 4", state);
      end
      #2;
      RESET_N = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || tx_start !== 1'b0 || req_ack !== 4'b0 || req_fail !== 4'b0 ||
          tx_id !== 11'h0 || tx_data !== 8'h0 || retry_cnt !== 3'd0 || bus_idle !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy_async: state=%0d start=%b ack=%b fail=%b id=%h data=%h retry=%0d idle=%b, want all 0",
                  state, tx_start, req_ack, req_fail, tx_id, tx_data, retry_cnt, bus_idle);
      end
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
      req     = '0;
      cyc();
      RESET_N = 1'b1;
      cyc(5);
      checks++;
      if (req_ack !== 4'b0 || req_fail !== 4'b0 || state !== 3'd0) begin
         errors++;
         $display("FAIL rst_busy_after: ack=%b fail=%b state=%0d, want 0/0/0", req_ack, req_fail, state);
      end
   endtask

   task automatic test_simultaneous_pulses();
      ticks(IDLE_BITS, 1'b1);
      tb_id[2] = 11'h222; tb_dat[2] = 8'h42;
      apply_cfg();
      req = 4'b0100;
      wait_launch(11'h222, 8'h42, 3'd0, "simul_de");
      node_pulse(1'b1, 1'b0, 1'b1, "simul_de");
      checks++;
      if (state !== 3'd5 || retry_cnt !== 3'd0) begin
         errors++;
         $display("FAIL simul_done_err: state=%0d retry=%0d, want 5/0", state, retry_cnt);
      end
      wait_resp(4'b0100, 4'b0000, "simul_de");
      release_req(2, "simul_de");
      req = 4'b0100;
      wait_launch(11'h222, 8'h42, 3'd0, "simul_le");
      node_pulse(1'b0, 1'b1, 1'b1, "simul_le");
      checks++;
      if (state !== 3'd1 || retry_cnt !== 3'd0) begin
         errors++;
         $display("FAIL simul_lost_err: state=%0d retry=%0d, want 1/0", state, retry_cnt);
      end
      wait_launch(11'h222, 8'h42, 3'd0, "simul_dl");
      node_pulse(1'b1, 1'b1, 1'b0, "simul_dl");
      checks++;
      if (state !== 3'd5) begin
         errors++;
         $display("FAIL simul_done_lost: state=%0d want 5", state);
      end
      wait_resp(4'b0100, 4'b0000, "simul_dl");
      release_req(2, "simul_dl");
   endtask

   task automatic test_withdraw();
      int base;
      base = launch_count;
      tb_id[1] = 11'h111; tb_dat[1] = 8'h0E;
      apply_cfg();
      req = 4'b0010;
      wait_launch(11'h111, 8'h0E, 3'd0, "withdraw");
      cyc();
      tick(1'b0);
      node_pulse(1'b0, 1'b0, 1'b1, "withdraw");
      cyc(3);
      checks++;
      if (state !== 3'd2 || retry_cnt !== 3'd1 || launch_count - base != 1) begin
         errors++;
         $display("FAIL withdraw_wait: state=%0d retry=%0d launches=%0d, want 2/1/1",
                  state, retry_cnt, launch_count - base);
      end
      tx_done = 1'b1;
      tx_lost = 1'b1;
      cyc();
      tx_done = 1'b0;
      tx_lost = 1'b0;
      cyc();
      checks++;
      if (state !== 3'd2 || req_ack !== 4'b0) begin
         errors++;
         $display("FAIL withdraw_ignore_pulse: state=%0d ack=%b, want 2/0000", state, req_ack);
      end
      req = '0;
      cyc();
      checks++;
      if (state !== 3'd0 || retry_cnt !== 3'd0) begin
         errors++;
         $display("FAIL withdraw_idle: state=%0d retry=%0d, want 0/0", state, retry_cnt);
      end
      ticks(IDLE_BITS, 1'b1);
      cyc(4);
      checks++;
      if (launch_count - base != 1 || req_ack !== 4'b0 || req_fail !== 4'b0) begin
         errors++;
         $display("FAIL withdraw_no_start: launches=%0d ack=%b fail=%b, want 1/0000/0000",
                  launch_count - base, req_ack, req_fail);
      end
   endtask

   task automatic test_onehot();
      checks++;
      if (onehot_viol != 0) begin
         errors++;
         $display("FAIL onehot: %0d cycles with more than one ack/fail bit, want 0", onehot_viol);
      end
   endtask

   initial begin
      test_reset();
      test_idle_counter();
      test_single();
      test_priority();
      test_random_arbitration();
      test_retry_limit();
      test_arb_loss();
      test_bus_gating();
      test_reset_mid_busy();
      test_simultaneous_pulses();
      test_withdraw();
      test_onehot();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
